// File: rtl/cookie_seq.sv
// cookie_seq: frame sequencer for one cookie cell array.
// Each frame loads CELLS seed bits into the array's load chain and advances
// `gens` generations. It then snapshots the array into the display chain and
// drains that chain as CELLS/8 bytes on a valid/ready output.

module cookie_seq #(
    parameter int CELLS = 256,
    parameter int GEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [GEN_W-1:0] gens,
    input  logic             load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             cookie_en,
    output logic             cookie_run,
    output logic             cookie_display,
    output logic             cookie_input_bit,
    input  logic             cookie_display_out,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(CELLS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        SNAP,
        DUMP,
        OUT,
        FIN
    } state_t;

    state_t             state;
    logic [GEN_W-1:0]   gen_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic               load_fire;

    // A seed bit is accepted and shifted into the array in the same cycle.
    assign load_fire = (state == LOAD) && load_valid;

    // Frame state machine, counters and the byte shift register.
    // NOTE: state is updated with non-blocking assignments so every branch
    // below reads the values from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gen_cnt  <= '0;
            bit_cnt  <= '0;
            out_byte <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gen_cnt <= gens;
                        bit_cnt <= '0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(CELLS - 1)) begin
                            state <= (gen_cnt == '0) ? SNAP : RUN;
                        end
                    end
                end
                RUN: begin
                    // Saturating countdown; the last run cycle is the one
                    // in which the count reaches zero.
                    if (gen_cnt != '0) begin
                        gen_cnt <= gen_cnt - GEN_W'(1);
                    end
                    if (gen_cnt <= GEN_W'(1)) begin
                        state <= SNAP;
                    end
                end
                SNAP: begin
                    bit_cnt <= '0;
                    state   <= DUMP;
                end
                DUMP: begin
                    // First sampled bit of each byte ends up in bit 7.
                    out_byte <= {out_byte[6:0], cookie_display_out};
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    if (bit_cnt[2:0] == 3'd7) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= (bit_cnt == CNT_W'(CELLS)) ? FIN : DUMP;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decoded from the registered state. Only the LOAD shift enable
    // depends on an input, so that the accept and the shift share a cycle.
    assign load_ready       = (state == LOAD);
    assign cookie_en        = load_fire || (state == RUN) || (state == DUMP);
    assign cookie_run       = (state == RUN);
    assign cookie_display   = (state == SNAP);
    assign cookie_input_bit = load_fire && load_data;
    assign out_valid        = (state == OUT);
    assign busy             = (state != IDLE);
    assign done             = (state == FIN);

endmodule

// File: tb/tb_cookie_seq.sv
// Testbench for cookie_seq. A behavioural model of the cookie array sits
// behind the sequencer. A scoreboard queue holds the bytes predicted from
// each seed, and a monitor pops and compares them at every output handshake.

module tb_cookie_seq;

    localparam int CELLS  = 256;
    localparam int GEN_W  = 8;
    localparam int NBYTES = CELLS / 8;
    localparam int BUDGET = 4000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [GEN_W-1:0] gens;
    logic             load_data;
    logic             load_valid;
    logic             load_ready;
    logic             cookie_en;
    logic             cookie_run;
    logic             cookie_display;
    logic             cookie_input_bit;
    logic             cookie_display_out;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    cookie_seq #(.CELLS(CELLS), .GEN_W(GEN_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .gens               (gens),
        .load_data          (load_data),
        .load_valid         (load_valid),
        .load_ready         (load_ready),
        .cookie_en          (cookie_en),
        .cookie_run         (cookie_run),
        .cookie_display     (cookie_display),
        .cookie_input_bit   (cookie_input_bit),
        .cookie_display_out (cookie_display_out),
        .out_byte           (out_byte),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .busy               (busy),
        .done               (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Generation rule of the modelled array (any fixed rule will do).
    function automatic logic [CELLS-1:0] gen_step(input logic [CELLS-1:0] c);
        logic [CELLS-1:0] n;
        for (int p = 0; p < CELLS; p++) begin
            n[p] = c[(p + 17) % CELLS] ^ c[(p * 3) % CELLS];
        end
        return n;
    endfunction

    // Array model: load chain == cell state, display chain drains from the top.
    logic [CELLS-1:0] cells;
    logic [CELLS-1:0] dchain;
    assign cookie_display_out = dchain[CELLS-1];

    always @(posedge clk) begin
        if (cookie_display) begin
            dchain <= cells;
        end else if (cookie_en && !cookie_run) begin
            cells  <= {cells[CELLS-2:0], cookie_input_bit};
            dchain <= {dchain[CELLS-2:0], 1'b0};
        end else if (cookie_en && cookie_run) begin
            cells <= gen_step(cells);
        end
    end

    // Scoreboard and reference model.
    logic [7:0] exp_q[$];

    function automatic void push_expected(input logic [CELLS-1:0] seed, input int g);
        logic [CELLS-1:0] grid;
        logic [7:0]       b;
        // seed[i] is the i-th bit sent; after CELLS shifts it sits at CELLS-1-i.
        for (int p = 0; p < CELLS; p++) grid[p] = seed[CELLS-1-p];
        for (int i = 0; i < g; i++) grid = gen_step(grid);
        for (int k = 0; k < NBYTES; k++) begin
            for (int j = 0; j < 8; j++) b[7-j] = grid[CELLS-1-8*k-j];
            exp_q.push_back(b);
        end
    endfunction

    function automatic logic [15:0] all_outs();
        return {load_ready, cookie_en, cookie_run, cookie_display, cookie_input_bit,
                out_valid, busy, done, out_byte};
    endfunction

    // Monitor statistics (written only by the monitor).
    int en_load = 0, en_dump = 0, run_cnt = 0, disp_cnt = 0, done_cnt = 0;
    int busy_cyc = 0, load_cyc = 0, bytes_seen = 0, stretch = 0, last_stretch = 0;

    initial begin : monitor
        bit         prev_run = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy) busy_cyc++;
                if (load_ready) begin
                    load_cyc++;
                    check(cookie_en == load_valid, "load_en", 64'(cookie_en), 64'(load_valid));
                    if (load_valid)
                        check(cookie_input_bit == load_data, "load_bit", 64'(cookie_input_bit), 64'(load_data));
                    if (cookie_en) en_load++;
                end else if (cookie_en && !cookie_run) begin
                    en_dump++;
                    check(cookie_input_bit == 1'b0, "dump_bit", 64'(cookie_input_bit), 64'(0));
                end
                if (cookie_run) begin
                    run_cnt++;
                    stretch++;
                    check(cookie_en == 1'b1, "run_en", 64'(cookie_en), 64'(1));
                end else if (prev_run) begin
                    check(cookie_display == 1'b1, "run_then_snap", 64'(cookie_display), 64'(1));
                    last_stretch = stretch;
                    stretch = 0;
                end
                prev_run = cookie_run;
                if (cookie_display) disp_cnt++;
                if (done) done_cnt++;
                if (out_valid && !out_ready) begin
                    check(cookie_en == 1'b0, "stall_en", 64'(cookie_en), 64'(0));
                    if (prev_stall) check(out_byte == prev_byte, "stall_hold", 64'(out_byte), 64'(prev_byte));
                end
                prev_stall = out_valid && !out_ready;
                prev_byte  = out_byte;
                if (out_valid && out_ready) begin
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_byte", 64'(out_byte), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check(out_byte == e, "byte", 64'(out_byte), 64'(e));
                    end
                end
            end
        end
    end

    task automatic timeout(input string name);
        check(1'b0, name, 64'(0), 64'(1));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    endtask

    // lv_mode: 0 always valid, 1 toggle (starting low), 2 random.
    // rdy_mode: 0 always ready, 1 random.
    task automatic run_frame(input logic [CELLS-1:0] seed, input int g, input int lv_mode,
                             input int rdy_mode, input int stall_byte, input int stall_len,
                             input int start_hold, input int abort_at);
        int  d_en_l, d_en_d, d_run, d_disp, d_done, d_busy, d_load, d_bytes;
        int  idx, cyc, bidx, stall_left;
        bit  got_done;
        bit  no_stall;
        d_en_l = en_load; d_en_d = en_dump; d_run = run_cnt; d_disp = disp_cnt;
        d_done = done_cnt; d_busy = busy_cyc; d_load = load_cyc; d_bytes = bytes_seen;
        no_stall = (lv_mode == 0) && (rdy_mode == 0) && (stall_len == 0);
        push_expected(seed, g);

        @(posedge clk); #1;
        gens  = GEN_W'(g);
        start = 1'b1;
        @(posedge clk); #1;
        gens  = GEN_W'($urandom);   // must already be captured
        idx = 0;
        cyc = 0;
        while (idx < CELLS) begin
            start = (cyc < start_hold);
            case (lv_mode)
                0:       load_valid = 1'b1;
                1:       load_valid = (cyc % 2 == 1);
                default: load_valid = 1'($urandom_range(0, 1));
            endcase
            load_data = load_valid ? seed[idx] : 1'($urandom);
            if (load_valid && load_ready) idx++;
            @(posedge clk); #1;
            cyc++;
            if (cyc > BUDGET) timeout("load_timeout");
        end
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = 1'b0;

        bidx = 0;
        cyc = 0;
        stall_left = stall_len;
        got_done = 1'b0;
        while (!got_done) begin
            if (abort_at > 0 && cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check(all_outs() == 16'h0, "abort_outs", 64'(all_outs()), 64'(0));
                check(done_cnt == d_done, "abort_no_done", 64'(done_cnt - d_done), 64'(0));
                exp_q.delete();
                out_ready = 1'b1;
                @(posedge clk); @(posedge clk); #1;
                check(all_outs() == 16'h0, "abort_idle", 64'(all_outs()), 64'(0));
                rst_n = 1'b1;
                return;
            end
            if (out_valid && bidx == stall_byte && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid && out_ready) bidx++;
            if (done) got_done = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (cyc > BUDGET) timeout("frame_timeout");
        end
        out_ready = 1'b1;

        check(all_outs()[15:8] == 8'h0, "idle_strobes", 64'(all_outs()[15:8]), 64'(0));
        check(done_cnt - d_done == 1, "done_pulses", 64'(done_cnt - d_done), 64'(1));
        check(en_load - d_en_l == CELLS, "en_load", 64'(en_load - d_en_l), 64'(CELLS));
        check(en_dump - d_en_d == CELLS, "en_dump", 64'(en_dump - d_en_d), 64'(CELLS));
        check(run_cnt - d_run == g, "run_cycles", 64'(run_cnt - d_run), 64'(g));
        check(disp_cnt - d_disp == 1, "snap_pulses", 64'(disp_cnt - d_disp), 64'(1));
        check(bytes_seen - d_bytes == NBYTES, "byte_count", 64'(bytes_seen - d_bytes), 64'(NBYTES));
        check(exp_q.size() == 0, "sb_empty", 64'(exp_q.size()), 64'(0));
        if (g > 0) check(last_stretch == g, "run_stretch", 64'(last_stretch), 64'(g));
        if (lv_mode == 0) check(load_cyc - d_load == CELLS, "load_len", 64'(load_cyc - d_load), 64'(CELLS));
        if (lv_mode == 1) check(load_cyc - d_load == 2 * CELLS, "load_len_toggle", 64'(load_cyc - d_load), 64'(2 * CELLS));
        if (no_stall)
            check(busy_cyc - d_busy == 546 + g, "frame_len", 64'(busy_cyc - d_busy), 64'(546 + g));
    endtask

    function automatic logic [CELLS-1:0] rand_seed();
        logic [CELLS-1:0] s;
        for (int i = 0; i < CELLS / 32; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    initial begin : driver
        logic [CELLS-1:0] s;
        rst_n      = 1'b0;
        start      = 1'b0;
        gens       = '0;
        load_data  = 1'b0;
        load_valid = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(all_outs() == 16'h0, "reset_outs", 64'(all_outs()), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check(all_outs() == 16'h0, "post_reset_idle", 64'(all_outs()), 64'(0));

        // All-zero seed, no generations.
        run_frame('0, 0, 0, 0, -1, 0, 0, 0);
        // Single 1 as the first bit: byte 0 = 8'h80.
        s = '0;
        s[0] = 1'b1;
        run_frame(s, 0, 0, 0, -1, 0, 0, 0);
        // Five generations.
        run_frame(rand_seed(), 5, 0, 0, -1, 0, 0, 0);
        // load_valid toggling every other cycle.
        run_frame(rand_seed(), int'($urandom_range(1, 20)), 1, 0, -1, 0, 0, 0);
        // Sink stalls 10 cycles on byte 3; start held high while busy.
        run_frame(rand_seed(), 3, 0, 0, 3, 10, 6, 0);
        // Reset in the middle of DUMP, then a complete frame.
        run_frame(rand_seed(), 0, 0, 0, -1, 0, 0, 30);
        run_frame(rand_seed(), 7, 0, 0, -1, 0, 0, 0);
        // Maximum generation count with random source and sink throttling.
        run_frame(rand_seed(), 255, 2, 1, -1, 0, 0, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
